shift_reg_n: RTL and testbench

SHIFT_REG_N -- requirements
Module: shift_reg_n

---
 rtl/shift_reg_n.sv | 107 ++++++++++
 tb/tb_shift_reg_n.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/shift_reg_n.sv
// Loadable N-bit shift register with multi-cycle left/right (logical or
// arithmetic) shifts of a latched count; registered Busy/Done handshake.
module shift_reg_n #(
  parameter int WIDTH = 16,
  parameter int CW    = $clog2(WIDTH+1)
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             Load,
  input  logic [WIDTH-1:0] D,
  input  logic             Start,
  input  logic [CW-1:0]    Count,
  input  logic             Dir,
  input  logic             Arith,
  input  logic             Serial_In,
  output logic [WIDTH-1:0] Data_Out,
  output logic             Serial_Out,
  output logic             Busy,
  output logic             Done
);

  typedef enum logic {IDLE, SHIFT} state_e;

  localparam logic [CW-1:0] WMAX = CW'(WIDTH);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             sout_q, sout_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             dir_q, dir_d;
  logic             arith_q, arith_d;
  logic             done_q, done_d;
  logic             busy_q, busy_d;
  logic [CW-1:0]    n_sat;
  logic             fill;

  assign n_sat = (Count > WMAX) ? WMAX : Count;
  assign fill  = arith_q ? data_q[WIDTH-1] : Serial_In;

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    sout_d  = sout_q;
    cnt_d   = cnt_q;
    dir_d   = dir_q;
    arith_d = arith_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        // Load has priority; a simultaneous Start is dropped.
        if (Load) begin
          data_d = D;
        end else if (Start) begin
          dir_d   = Dir;
          arith_d = Arith;
          cnt_d   = n_sat;
          if (n_sat == '0) done_d  = 1'b1;
          else             state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (dir_q) begin
          data_d = {data_q[WIDTH-2:0], Serial_In};
          sout_d = data_q[WIDTH-1];
        end else begin
          data_d = {fill, data_q[WIDTH-1:1]};
          sout_d = data_q[0];
        end
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == SHIFT);
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= IDLE;
      data_q  <= '0;
      sout_q  <= 1'b0;
      cnt_q   <= '0;
      dir_q   <= 1'b0;
      arith_q <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      sout_q  <= sout_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
      arith_q <= arith_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  assign Data_Out   = data_q;
  assign Serial_Out = sout_q;
  assign Busy       = busy_q;
  assign Done       = done_q;

endmodule

// File: tb/tb_shift_reg_n.sv
// Scoreboard bench: stimulus pushes expected end-of-operation results, a
// negedge monitor pops and checks them on every Done pulse.
module tb_shift_reg_n;

  logic        Clk = 1'b0;
  logic        Reset_n;
  logic        Load, Start, Dir, Arith, Serial_In;
  logic [15:0] D;
  logic [4:0]  Count;
  logic [15:0] Data_Out;
  logic        Serial_Out, Busy, Done;

  logic        Load8, Start8, Dir8, Arith8, SerIn8;
  logic [7:0]  D8, Data_Out8;
  logic [3:0]  Count8;
  logic        Serial_Out8, Busy8, Done8;

  always #5 Clk = ~Clk;

  shift_reg_n #(.WIDTH(16)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .Load(Load), .D(D), .Start(Start),
    .Count(Count), .Dir(Dir), .Arith(Arith), .Serial_In(Serial_In),
    .Data_Out(Data_Out), .Serial_Out(Serial_Out), .Busy(Busy), .Done(Done));

  shift_reg_n #(.WIDTH(8)) dut8 (
    .Clk(Clk), .Reset_n(Reset_n), .Load(Load8), .D(D8), .Start(Start8),
    .Count(Count8), .Dir(Dir8), .Arith(Arith8), .Serial_In(SerIn8),
    .Data_Out(Data_Out8), .Serial_Out(Serial_Out8), .Busy(Busy8), .Done(Done8));

  typedef struct {
    logic [63:0] data;
    logic        so;
    int          busy;
  } exp_t;

  exp_t        q[$];
  int          nvec = 0;
  int          nfail = 0;
  int          busy_cnt = 0;
  logic [63:0] exp_data = '0;
  logic        exp_sout = 1'b0;

  function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endfunction

  // Result of n shifts taken straight from the shift rules: bulk shift plus
  // placement of each serial bit at its final position.
  function automatic void model(input int w, input logic [63:0] d, input int n,
                                input bit dir, input bit ar, input logic [63:0] seq,
                                input logic so_prev, output logic [63:0] r, output logic so);
    logic [63:0] mask;
    mask = (64'd1 << w) - 64'd1;
    if (n == 0) begin
      r = d; so = so_prev;
    end else if (dir) begin
      r = (d << n) & mask;
      for (int i = 0; i < n; i++) r[n-1-i] = seq[i];
      so = d[w-n];
    end else begin
      r = d >> n;
      if (ar) begin
        if (d[w-1]) r = r | (mask & ~(mask >> n));
      end else begin
        for (int i = 0; i < n; i++) r[w-n+i] = seq[i];
      end
      so = d[n-1];
    end
  endfunction

  always @(negedge Clk) begin
    exp_t e;
    if (!Reset_n) busy_cnt = 0;
    else begin
      if (Busy) busy_cnt++;
      if (Done) begin
        if (q.size() == 0) begin
          nvec++; nfail++;
          $display("FAIL spurious_done: got Done=1 expected no pending operation");
        end else begin
          e = q.pop_front();
          chk("data_out", 64'(Data_Out), e.data);
          chk("serial_out", 64'(Serial_Out), 64'(e.so));
          chk("busy_cycles", 64'(busy_cnt), 64'(e.busy));
        end
        busy_cnt = 0;
      end
    end
  end

  // Entered and left at posedge+1; a following op is thus issued in the Done cycle.
  task automatic op(input bit ld, input logic [15:0] d, input bit st, input int cnt,
                    input bit dir, input bit ar, input logic [63:0] seq, input bit noise);
    int n;
    logic [63:0] r;
    logic so;
    exp_t e;
    Load = ld; D = d; Start = st; Count = 5'(cnt); Dir = dir; Arith = ar;
    n = 0;
    if (ld) exp_data = 64'(d);
    else if (st) begin
      n = (cnt > 16) ? 16 : cnt;
      model(16, exp_data, n, dir, ar, seq, exp_sout, r, so);
      e.data = r; e.so = so; e.busy = n;
      q.push_back(e);
      exp_data = r; exp_sout = so;
    end
    @(posedge Clk); #1;
    Load = 1'b0; Start = 1'b0;
    for (int i = 0; i < n; i++) begin
      Serial_In = seq[i];
      if (noise) begin
        Load = 1'($urandom); D = 16'h1234; Start = 1'($urandom);
        Dir = 1'($urandom); Arith = 1'($urandom); Count = 5'($urandom);
      end
      @(posedge Clk); #1;
    end
    Load = 1'b0; Start = 1'b0;
  endtask

  initial begin
    logic [63:0] r;
    logic so;
    int waited;
    Reset_n = 1'b0; Load = 0; Start = 0; Dir = 0; Arith = 0; Serial_In = 0;
    D = '0; Count = '0;
    Load8 = 0; Start8 = 0; Dir8 = 0; Arith8 = 0; SerIn8 = 0; D8 = '0; Count8 = '0;
    #3;
    chk("rst_data", 64'(Data_Out), 64'd0);
    chk("rst_sout", 64'(Serial_Out), 64'd0);
    chk("rst_busy", 64'(Busy), 64'd0);
    chk("rst_done", 64'(Done), 64'd0);
    #9 Reset_n = 1'b1;
    @(posedge Clk); #1;

    op(1, 16'hA5C3, 0, 0, 0, 0, 64'd0, 0);
    op(0, 16'h0, 1, 4, 0, 0, 64'd0, 0);
    op(1, 16'h8001, 0, 0, 0, 0, 64'd0, 0);
    op(0, 16'h0, 1, 3, 0, 1, 64'd0, 1);
    op(1, 16'h00FF, 0, 0, 0, 0, 64'd0, 0);
    op(0, 16'h0, 1, 20, 1, 0, '1, 1);
    op(0, 16'h0, 1, 0, 0, 0, 64'd0, 0);
    op(1, 16'h5A5A, 1, 5, 0, 0, 64'd0, 0);
    op(0, 16'h0, 1, 0, 1, 1, 64'd0, 0);
    op(1, 16'h9234, 0, 0, 0, 0, 64'd0, 0);
    op(0, 16'h0, 1, 31, 0, 1, 64'd0, 1);
    op(1, 16'h7FFF, 0, 0, 0, 0, 64'd0, 0);
    op(0, 16'h0, 1, 16, 0, 0, {$urandom, $urandom}, 1);

    for (int k = 0; k < 40; k++)
      op(($urandom % 4) == 0, 16'($urandom), ($urandom % 8) != 0, int'($urandom % 32),
         1'($urandom), 1'($urandom), {$urandom, $urandom}, 1'($urandom));

    // Abort a shift with an asynchronous reset between edges.
    Start = 1'b1; Count = 5'd10; Dir = 1'b0; Arith = 1'b0;
    @(posedge Clk); #1 Start = 1'b0;
    @(posedge Clk); @(posedge Clk); #3 Reset_n = 1'b0;
    #1;
    chk("abort_data", 64'(Data_Out), 64'd0);
    chk("abort_sout", 64'(Serial_Out), 64'd0);
    chk("abort_busy", 64'(Busy), 64'd0);
    chk("abort_done", 64'(Done), 64'd0);
    @(negedge Clk); #2 Reset_n = 1'b1;
    exp_data = '0; exp_sout = 1'b0;
    @(posedge Clk); #1;
    op(1, 16'hBEEF, 0, 0, 0, 0, 64'd0, 0);
    op(0, 16'h0, 1, 0, 0, 0, 64'd0, 0);
    op(0, 16'h0, 1, 2, 1, 0, 64'd2, 0);
    repeat (3) @(posedge Clk);
    #1 chk("pending_ops", 64'(q.size()), 64'd0);

    // Narrow instance, checked directly against the same model.
    Load8 = 1'b1; D8 = 8'hC3;
    @(posedge Clk); #1 Load8 = 1'b0; Start8 = 1'b1; Count8 = 4'd2;
    @(posedge Clk); #1 Start8 = 1'b0;
    model(8, 64'hC3, 2, 0, 0, 64'd0, 1'b0, r, so);
    waited = 0;
    while (!Done8 && waited < 20) begin @(negedge Clk); waited++; end
    chk("w8_done_seen", 64'(Done8), 64'd1);
    chk("w8_data", 64'(Data_Out8), r);
    chk("w8_sout", 64'(Serial_Out8), 64'(so));

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
